pc_fetch: RTL
=============

# pc_fetch

Program-counter and fetch-control stage of the single-cycle MIPS CPU. It sits directly upstream of the instruction ROM and drives the ROM's byte address every cycle. It selects the next PC from the decode and execute results (sequential, branch, jump, jr), and enforces stall, halt and address-fault behaviour. It also keeps cycle and retired-instruction counters for debug.

## Interface

Parameters:
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `ADDR_SPACE`, 255: highest valid word index of the instruction ROM.

Ports:
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `stall`, in, 1: hold the PC this cycle; the instruction does not retire.
- `branch_taken`, in, 1: conditional branch resolved taken.
- `branch_offset`, in, 32: sign-extended 16-bit immediate (word offset).
- `jump`, in, 1: j/jal decoded.
- `jump_target`, in, 26: instr[25:0].
- `jr`, in, 1: jr/jalr decoded.
- `jr_addr`, in, 32: register-file rs value.
- `halt_req`, in, 1: halt instruction decoded (syscall/break).
- `pc`, out, 32: current PC; drives the ROM byte address.
- `pc_plus4`, out, 32: `pc` + 4; used as the link value for jal/jalr.
- `halted`, out, 1: state is HALT.
- `addr_fault`, out, 1: state is FAULT.
- `fault_pc`, out, 32: offending next-PC value captured on a fault.
- `cycle_count`, out, 32: number of clock cycles spent in RUN.
- `instr_count`, out, 32: number of retired instructions.

## Operation

- States: RUN, HALT, FAULT. HALT and FAULT are sticky; only `rst` exits them.
- Next-PC selection in RUN, in priority order:
  - `stall`: hold `pc`. All other requests are ignored, including `halt_req`.
  - `halt_req`: hold `pc`; go to HALT.
  - `jr`: next PC = `jr_addr`.
  - `jump`: next PC = {`pc_plus4`[31:28], `jump_target`, 2'b00}.
  - `branch_taken`: next PC = `pc_plus4` + (`branch_offset` << 2).
  - Otherwise: next PC = `pc_plus4`.
- Arithmetic is 32-bit modulo 2^32. Overflow wraps silently and is then subject to the range check.
- Fault check, applied to every candidate next PC that is not a hold:
  - The candidate faults if bits [1:0] ≠ 0, or if (candidate >> 2) > `ADDR_SPACE`.
  - On a fault, `pc` is not loaded; `fault_pc` ← candidate; go to FAULT.
- Counters, both wrapping at 2^32:
  - `cycle_count` increments on every RUN cycle, stalled or not.
  - `instr_count` increments on every non-stalled RUN cycle. This includes the cycle carrying `halt_req` and the cycle whose instruction produces a faulting next PC.
- In HALT or FAULT:
  - `pc`, both counters and `fault_pc` are frozen.
  - All inputs are ignored.

## Timing

- `pc` is registered. The next PC is computed combinationally from the current-cycle inputs and loaded on the next rising edge, giving 1-cycle latency from a decision to a new `pc`.
- `pc_plus4` is combinational from `pc`.
- `halted` and `addr_fault` assert on the edge that makes the transition, i.e. in the first cycle after the request.
- Reset values, applied immediately on `rst` assertion with no clock needed:
  - `pc` = `RESET_PC`; `pc_plus4` = `RESET_PC` + 4.
  - State = RUN; `halted` = 0; `addr_fault` = 0.
  - `fault_pc` = 0; `cycle_count` = 0; `instr_count` = 0.
- Reset mid-operation, including in HALT or FAULT, aborts everything. Fetch restarts at `RESET_PC` on the first edge after `rst` deasserts.
- Simultaneous `jr` + `jump` + `branch_taken`: `jr` wins; the others are dropped without error.

## Structure

- Shared package `mips_pkg`:
  - state enum {RUN, HALT, FAULT};
  - the default `RESET_PC`;
  - the constants `WORD_BITS` = 2 and `PC_W` = 32.
- Natural sub-module `pc_next_logic`: purely combinational next-PC mux plus the fault check. It outputs the candidate PC and a fault flag.
- The top level holds the state register, `pc`, `fault_pc` and both counters.

## Test plan

- **Sequential fetch**: `rst` pulse, then 3 free cycles → `pc` goes 0x0, 0x4, 0x8, 0xC; `instr_count` = 3; `cycle_count` = 3.
- **Backward branch**: at `pc` = 0x10, `branch_taken` = 1 and `branch_offset` = 0xFFFFFFFE → `pc` = 0x0C. With `branch_offset` = 3 from 0x10 → `pc` = 0x20.
- **Jump and jr priority**:
  - At `pc` = 0x20, `jump` with `jump_target` = 26'h40 → `pc` = 0x100.
  - Same cycle with `jr` = 1 and `jr_addr` = 0x44 → `pc` = 0x44.
- **Stall**: at `pc` = 0x8, `stall` = 1 for 2 cycles with `branch_taken` = 1 and `halt_req` = 1 → `pc` stays 0x8; `cycle_count` +2; `instr_count` unchanged; `halted` = 0.
- **Address faults**:
  - `jr_addr` = 0x402 → `addr_fault` = 1, `fault_pc` = 0x402, `pc` held. Later inputs are ignored.
  - After reset, `jr_addr` = 0x400 (index 256 > 255) → fault; 0x3FC → no fault.
- **Halt and reset**: `halt_req` at `pc` = 0x30 → next cycle `halted` = 1, `pc` = 0x30, counters frozen. Asserting `rst` mid-cycle → `pc` = `RESET_PC` and `halted` = 0 before the next edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the single-cycle MIPS fetch path.
package mips_pkg;

    localparam int unsigned PC_W      = 32;
    localparam int unsigned WORD_BITS = 2;

    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // RUN fetches; HALT and FAULT are sticky until reset.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } state_e;

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection and instruction-address range/alignment check.
module pc_next_logic
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_SPACE = 255
) (
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] pc_plus4,
    input  logic            stall,
    input  logic            halt_req,
    input  logic            jr,
    input  logic [PC_W-1:0] jr_addr,
    input  logic            jump,
    input  logic [25:0]     jump_target,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_offset,
    output logic [PC_W-1:0] next_pc,
    output logic            hold,
    output logic            fault
);

    logic [PC_W-1:0] word_idx;

    // Priority mux: stall > halt > jr > jump > branch > sequential.
    always_comb begin
        hold    = stall | halt_req;
        next_pc = pc_plus4;
        if (hold) begin
            next_pc = pc;
        end else if (jr) begin
            next_pc = jr_addr;
        end else if (jump) begin
            next_pc = {pc_plus4[31:28], jump_target, 2'b00};
        end else if (branch_taken) begin
            next_pc = pc_plus4 + {branch_offset[PC_W-3:0], 2'b00};
        end
    end

    // A held PC never faults; otherwise check alignment and ROM word range.
    always_comb begin
        word_idx = {2'b00, next_pc[PC_W-1:WORD_BITS]};
        fault    = !hold && ((next_pc[WORD_BITS-1:0] != '0) || (word_idx > ADDR_SPACE));
    end

endmodule

// File: rtl/pc_fetch.sv
// Program counter, fetch state and debug counters for the single-cycle MIPS core.
module pc_fetch
    import mips_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned     ADDR_SPACE = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_offset,
    input  logic            jump,
    input  logic [25:0]     jump_target,
    input  logic            jr,
    input  logic [PC_W-1:0] jr_addr,
    input  logic            halt_req,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus4,
    output logic            halted,
    output logic            addr_fault,
    output logic [PC_W-1:0] fault_pc,
    output logic [31:0]     cycle_count,
    output logic [31:0]     instr_count
);

    state_e          state;
    logic [PC_W-1:0] next_pc;
    logic            hold;
    logic            fault;

    // Link value and sequential successor.
    always_comb begin
        pc_plus4   = pc + 32'd4;
        halted     = (state == HALT);
        addr_fault = (state == FAULT);
    end

    pc_next_logic #(
        .ADDR_SPACE (ADDR_SPACE)
    ) u_next (
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .stall         (stall),
        .halt_req      (halt_req),
        .jr            (jr),
        .jr_addr       (jr_addr),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .next_pc       (next_pc),
        .hold          (hold),
        .fault         (fault)
    );

    // State, PC, fault capture and counters; everything freezes outside RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            pc          <= RESET_PC;
            fault_pc    <= '0;
            cycle_count <= '0;
            instr_count <= '0;
        end else if (state == RUN) begin
            cycle_count <= cycle_count + 32'd1;
            if (!stall) begin
                // Halting and faulting instructions still count as retired.
                instr_count <= instr_count + 32'd1;
                if (halt_req) begin
                    state <= HALT;
                end else if (fault) begin
                    fault_pc <= next_pc;
                    state    <= FAULT;
                end else begin
                    pc <= next_pc;
                end
            end
        end
    end

endmodule
